// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX op -> data-memory access -> extended load data/exception to writeback.
// Latency: accept->rsp_valid 1 cycle for illegal ops, >=2 cycles for memory accesses (ack-dependent, bounded by TIMEOUT).
// Backpressure: req_ready only in IDLE; rsp_* held stable until rsp_ready, one op in flight at a time.
module mem_stage_lsu #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_dst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_dst,
    output logic [1:0]  rsp_exc,
    output logic        busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd3, OP_SH = 3'd4, OP_SB = 3'd5;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [1:0]      lo_q;
    logic [4:0]      dst_q;
    logic [CW-1:0]   cnt;

    logic            is_store, is_rsvd, misalign, in_range, illegal;
    logic [31:0]     word_addr;
    logic [3:0]      be_n;
    logic [31:0]     wdata_n;
    logic [31:0]     load_ext;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign word_addr = {req_addr[31:2], 2'b00};
    assign is_store  = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);
    assign is_rsvd   = (req_op[2:1] == 2'b11);
    assign misalign  = (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00)) ||
                       (((req_op == OP_LH) || (req_op == OP_SH)) && req_addr[0]);
    // Offset compare handles both bounds in one unsigned test (wraps below ADDR_LO).
    assign in_range  = ((word_addr - ADDR_LO) <= (ADDR_HI - 32'd3 - ADDR_LO));
    assign illegal   = is_rsvd || misalign || !in_range;

    always_comb begin
        be_n    = 4'hF;
        wdata_n = 32'h0;
        case (req_op)
            OP_SW: wdata_n = req_wdata;
            OP_SH: begin
                be_n    = req_addr[1] ? 4'hC : 4'h3;
                wdata_n = {2{req_wdata[15:0]}};
            end
            OP_SB: begin
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            default: be_n = 4'hF;
        endcase
    end

    always_comb begin
        load_ext = mem_rdata;
        case (op_q)
            OP_LH: load_ext = lo_q[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                      : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            OP_LB: begin
                case (lo_q)
                    2'd0:    load_ext = {{24{mem_rdata[7]}},  mem_rdata[7:0]};
                    2'd1:    load_ext = {{24{mem_rdata[15]}}, mem_rdata[15:8]};
                    2'd2:    load_ext = {{24{mem_rdata[23]}}, mem_rdata[23:16]};
                    default: load_ext = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
                endcase
            end
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= 3'd0;
            lo_q      <= 2'd0;
            dst_q     <= 5'd0;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
            rsp_dst   <= 5'd0;
            rsp_exc   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        lo_q  <= req_addr[1:0];
                        dst_q <= req_dst;
                        if (illegal) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 32'h0;
                            rsp_dst   <= 5'd0;
                            rsp_exc   <= is_store ? 2'd2 : 2'd1;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= word_addr;
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack || (cnt == CNT_LAST)) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'h0;
                        mem_wdata <= 32'h0;
                        rsp_valid <= 1'b1;
                        // An ack on the final timeout cycle still counts as a normal completion.
                        if (mem_ack && !mem_we) begin
                            rsp_data <= load_ext;
                            rsp_dst  <= dst_q;
                            rsp_exc  <= 2'd0;
                        end else begin
                            rsp_data <= 32'h0;
                            rsp_dst  <= 5'd0;
                            rsp_exc  <= mem_ack ? 2'd0 : 2'd3;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= 32'h0;
                        rsp_dst   <= 5'd0;
                        rsp_exc   <= 2'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
